// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 130x128 limb multiplier among NUM_REQ clients.
// Define MULT_ARB_TIMEOUT_EN to add a WAIT-state watchdog that returns rsp_err on expiry.
module mult_share_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*130-1:0] req_a,
    input  logic [NUM_REQ*128-1:0] req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [257:0]           rsp_product,
    output logic                   rsp_err,
    output logic                   arb_busy,
    output logic                   mul_start,
    output logic [129:0]           mul_a,
    output logic [127:0]           mul_b,
    input  logic                   mul_busy,
    input  logic                   mul_done,
    input  logic [257:0]           mul_product
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int SUM_W = PTR_W + 1;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("mult_share_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   r_gnt;
    logic [PTR_W-1:0]   w_gnt_nxt;
    logic [129:0]       r_mul_a;
    logic [129:0]       w_mul_a_nxt;
    logic [127:0]       r_mul_b;
    logic [127:0]       w_mul_b_nxt;
    logic [257:0]       r_rsp_product;
    logic [257:0]       w_product_nxt;

    logic [NUM_REQ-1:0] w_rot;
    logic               w_gnt_found;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [SUM_W-1:0]   w_sum;
    logic [129:0]       w_sel_a;
    logic [127:0]       w_sel_b;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic               r_rsp_err;
    logic               w_err_nxt;
    logic [TMO_W-1:0]   r_tmo;
    logic [TMO_W-1:0]   w_tmo_nxt;
`endif

    // Rotate requests so bit 0 is the pointer's client, then take the first set bit.
    always_comb begin
        w_rot       = NUM_REQ'({req_valid, req_valid} >> r_ptr);
        w_gnt_found = 1'b0;
        w_gnt_idx   = r_ptr;
        w_sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_gnt_found && w_rot[k]) begin
                w_gnt_found = 1'b1;
                w_sum       = {1'b0, r_ptr} + SUM_W'(k);
                if (w_sum >= SUM_W'(NUM_REQ)) begin
                    w_sum = w_sum - SUM_W'(NUM_REQ);
                end
                w_gnt_idx = w_sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == PTR_W'(i)) begin
                w_sel_a = req_a[i*130 +: 130];
                w_sel_b = req_b[i*128 +: 128];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_nxt     = r_gnt;
        w_mul_a_nxt   = r_mul_a;
        w_mul_b_nxt   = r_mul_b;
        w_product_nxt = r_rsp_product;
`ifdef MULT_ARB_TIMEOUT_EN
        w_err_nxt     = r_rsp_err;
        w_tmo_nxt     = r_tmo;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_gnt_found) begin
                    w_gnt_nxt   = w_gnt_idx;
                    w_mul_a_nxt = w_sel_a;
                    w_mul_b_nxt = w_sel_b;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mul_busy) begin
                    w_state_nxt = S_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                    w_tmo_nxt   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (mul_done) begin
                    w_product_nxt = mul_product;
                    w_state_nxt   = S_RESP;
`ifdef MULT_ARB_TIMEOUT_EN
                    w_err_nxt     = 1'b0;
                end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Watchdog expiry: answer the client with a zero product and an error flag.
                    w_product_nxt = '0;
                    w_err_nxt     = 1'b1;
                    w_state_nxt   = S_RESP;
                end else begin
                    w_tmo_nxt     = r_tmo + 1'b1;
`endif
                end
            end
            S_RESP: begin
                w_ptr_nxt   = (r_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_gnt         <= '0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_rsp_product <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            r_rsp_err     <= 1'b0;
            r_tmo         <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_gnt         <= w_gnt_nxt;
            r_mul_a       <= w_mul_a_nxt;
            r_mul_b       <= w_mul_b_nxt;
            r_rsp_product <= w_product_nxt;
`ifdef MULT_ARB_TIMEOUT_EN
            r_rsp_err     <= w_err_nxt;
            r_tmo         <= w_tmo_nxt;
`endif
        end
    end

    // The accept strobe is gated by reset so every output reads 0 while reset is held.
    assign req_ready   = (r_state == S_IDLE && w_gnt_found && !reset)
                         ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign rsp_valid   = (r_state == S_RESP) ? (NUM_REQ'(1) << r_gnt) : '0;
    assign rsp_product = r_rsp_product;
    assign arb_busy    = (r_state != S_IDLE);
    assign mul_start   = (r_state == S_ISSUE);
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
`ifdef MULT_ARB_TIMEOUT_EN
    assign rsp_err     = r_rsp_err;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural multiplier model.
`timescale 1ns/1ps
module tb_mult_share_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TMO     = 8;

    typedef struct {
        logic [1:0]   vld;
        logic [257:0] prod;
        logic         err;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ*130-1:0] req_a = '0;
    logic [NUM_REQ*128-1:0] req_b = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [257:0]           rsp_product;
    logic                   rsp_err;
    logic                   arb_busy;
    logic                   mul_start;
    logic [129:0]           mul_a;
    logic [127:0]           mul_b;
    logic                   mul_busy = 1'b0;
    logic                   mul_done = 1'b0;
    logic [257:0]           mul_product = '0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int rsp_seen = 0;
    int acc_cyc = 0;
    int rsp_cyc = 0;
    int ready_pulses = 0;
    int start_cycles = 0;
    int start_unstable = 0;
    logic [129:0] start_a = '0;
    logic [127:0] start_b = '0;

    int mul_lat = 1;
    int m_cnt = 0;
    int busy_arm = 0;
    int busy_hold = 0;
    bit m_suppress = 1'b0;
    logic [257:0] m_prod = '0;

    exp_t sb[$];
    exp_t mon_e;

    mult_share_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_err(rsp_err),
        .arb_busy(arb_busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_busy(mul_busy), .mul_done(mul_done), .mul_product(mul_product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [257:0] act, input logic [257:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Multiplier model: changes its outputs on the falling edge so the DUT sees them at the next rise.
    always @(negedge clk) begin
        mul_done = 1'b0;
        mul_product = '0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && !m_suppress) begin
                mul_done = 1'b1;
                mul_product = m_prod;
            end
        end
        if (busy_arm > 0 && mul_start) begin
            busy_hold = busy_arm;
            busy_arm = 0;
        end
        if (busy_hold > 0) begin
            mul_busy = 1'b1;
            busy_hold--;
        end else begin
            mul_busy = 1'b0;
        end
        if (mul_start && !mul_busy) begin
            m_cnt = mul_lat;
            m_prod = 258'(mul_a) * 258'(mul_b);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (req_ready != '0) begin
                ready_pulses++;
                acc_cyc = cyc;
                chk("ready_onehot", 258'($countones(req_ready)), 258'(1));
            end
            if (mul_start) begin
                if (start_cycles == 0) begin
                    start_a = mul_a;
                    start_b = mul_b;
                end else if (mul_a !== start_a || mul_b !== start_b) begin
                    start_unstable++;
                end
                start_cycles++;
            end
            if (rsp_valid != '0) begin
                rsp_seen++;
                rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 258'(rsp_valid), 258'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_valid", 258'(rsp_valid), 258'(mon_e.vld));
                    chk("rsp_product", rsp_product, mon_e.prod);
                    chk("rsp_err", 258'(rsp_err), 258'(mon_e.err));
                end
            end
        end
    end

    task automatic clr_stats();
        ready_pulses = 0;
        start_cycles = 0;
        start_unstable = 0;
    endtask

    task automatic set_valid(input int c, input logic v);
        if (c == 0) req_valid[0] = v;
        else req_valid[1] = v;
    endtask

    task automatic drive_req(input int c, input logic [129:0] a, input logic [127:0] b);
        if (c == 0) begin
            req_a[129:0] = a;
            req_b[127:0] = b;
        end else begin
            req_a[259:130] = a;
            req_b[255:128] = b;
        end
        set_valid(c, 1'b1);
    endtask

    task automatic push_exp(input int c, input logic [257:0] p, input logic e);
        exp_t x;
        x.vld = (c == 0) ? 2'b01 : 2'b10;
        x.prod = p;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic wait_accept(input int c);
        bit got;
        logic [31:0] cv;
        got = 1'b0;
        cv = c;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (req_ready[cv[0]]) got = 1'b1;
        end
        chk("accept_seen", 258'(got), 258'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int target);
        int k;
        k = 0;
        while (rsp_seen < target && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("rsp_arrived", 258'(rsp_seen >= target), 258'(1));
    endtask

    task automatic do_job(input int c, input logic [129:0] a, input logic [127:0] b,
                          input int lat, input int busy);
        int tgt;
        clr_stats();
        mul_lat = lat;
        busy_arm = busy;
        push_exp(c, 258'(a) * 258'(b), 1'b0);
        tgt = rsp_seen + 1;
        drive_req(c, a, b);
        wait_accept(c);
        set_valid(c, 1'b0);
        wait_rsp(tgt);
        chk("latency", 258'(rsp_cyc - acc_cyc), 258'(2 + busy + lat));
        chk("ready_pulses", 258'(ready_pulses), 258'(1));
        chk("start_cycles", 258'(start_cycles), 258'(1 + busy));
        chk("start_stable", 258'(start_unstable), 258'(0));
        chk("start_a", 258'(start_a), 258'(a));
        chk("start_b", 258'(start_b), 258'(b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [258:0] w259;
        int tgt;
        int snap;

        repeat (2) @(negedge clk);
        chk("rst_busy", 258'(arb_busy), 258'(0));
        chk("rst_start", 258'(mul_start), 258'(0));
        chk("rst_rsp_valid", 258'(rsp_valid), 258'(0));
        chk("rst_product", rsp_product, 258'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_job(0, 130'd3, 128'd5, 1, 0);
        chk("single_product", rsp_product, 258'd15);
        chk("single_err", 258'(rsp_err), 258'(0));

        do_job(1, 130'd1000, 128'd77, 3, 0);

        // Both clients held for four jobs; pointer is 0 here.
        clr_stats();
        mul_lat = 2;
        push_exp(0, 258'd63, 1'b0);
        push_exp(1, 258'd143, 1'b0);
        push_exp(0, 258'd63, 1'b0);
        push_exp(1, 258'd143, 1'b0);
        tgt = rsp_seen + 4;
        drive_req(0, 130'd7, 128'd9);
        drive_req(1, 130'd11, 128'd13);
        wait_rsp(tgt);
        set_valid(0, 1'b0);
        set_valid(1, 1'b0);
        chk("contend_accepts", 258'(ready_pulses), 258'(4));
        chk("contend_sb_empty", 258'(sb.size()), 258'(0));

        do_job(1, 130'h2_dead_beef, 128'h1234_5678_9abc, 2, 5);

        do_job(0, {130{1'b1}}, {128{1'b1}}, 3, 0);
        w259 = (259'(1) << 258) - (259'(1) << 130) - (259'(1) << 128) + 259'(1);
        chk("wide_product", rsp_product, w259[257:0]);
        chk("wide_msb", 258'(rsp_product[257]), 258'(1));

        // Abort a client-1 job in WAIT; pointer is 1 beforehand.
        mul_lat = 20;
        drive_req(1, 130'd5, 128'd6);
        wait_accept(1);
        set_valid(1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_busy", 258'(arb_busy), 258'(1));
        chk("pre_reset_start", 258'(mul_start), 258'(0));
        reset = 1'b1;
        #1;
        chk("arst_ready", 258'(req_ready), 258'(0));
        chk("arst_rsp_valid", 258'(rsp_valid), 258'(0));
        chk("arst_product", rsp_product, 258'(0));
        chk("arst_err", 258'(rsp_err), 258'(0));
        chk("arst_busy", 258'(arb_busy), 258'(0));
        chk("arst_start", 258'(mul_start), 258'(0));
        chk("arst_mul_a", 258'(mul_a), 258'(0));
        chk("arst_mul_b", 258'(mul_b), 258'(0));
        @(negedge clk);
        reset = 1'b0;
        snap = rsp_seen;
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_rsp", 258'(rsp_seen), 258'(snap));

        mul_lat = 1;
        push_exp(0, 258'd24, 1'b0);
        push_exp(1, 258'd35, 1'b0);
        tgt = rsp_seen + 2;
        drive_req(0, 130'd4, 128'd6);
        drive_req(1, 130'd5, 128'd7);
        wait_rsp(tgt);
        set_valid(0, 1'b0);
        set_valid(1, 1'b0);
        chk("post_reset_sb_empty", 258'(sb.size()), 258'(0));

`ifdef MULT_ARB_TIMEOUT_EN
        mul_lat = 15;
        push_exp(0, 258'd0, 1'b1);
        tgt = rsp_seen + 1;
        drive_req(0, 130'd9, 128'd9);
        wait_accept(0);
        set_valid(0, 1'b0);
        wait_rsp(tgt);
        chk("timeout_latency", 258'(rsp_cyc - acc_cyc), 258'(2 + TMO));
        repeat (20) @(posedge clk);
        #1;
        chk("stray_done_ignored", 258'(rsp_seen), 258'(tgt));
        chk("timeout_idle", 258'(arb_busy), 258'(0));
`else
        m_suppress = 1'b1;
        mul_lat = 4;
        drive_req(0, 130'd9, 128'd9);
        wait_accept(0);
        set_valid(0, 1'b0);
        snap = rsp_seen;
        repeat (30) @(posedge clk);
        #1;
        chk("stuck_busy", 258'(arb_busy), 258'(1));
        chk("stuck_no_start", 258'(mul_start), 258'(0));
        chk("stuck_no_rsp", 258'(rsp_seen), 258'(snap));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_suppress = 1'b0;
        #1;
        chk("stuck_cleared", 258'(arb_busy), 258'(0));
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one 130x128 limb multiplier between NUM_REQ clients, e.g. the Poly1305 accumulator and the GHASH/tag-finalisation path.
- Accepts one operand pair at a time, issues a one-cycle start to the multiplier and waits for its done pulse.
- Returns the 258-bit product to the granted client, tagged by a one-hot response valid.
- Sits between the client engines and the multiplier instance in the AEAD datapath.

Parameters:
- NUM_REQ, 2, number of requesting clients (2..8).
- TIMEOUT_CYCLES, 32, watchdog limit in cycles from start acceptance to mul_done; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-client request; held until accepted.
- req_a  in  NUM_REQ*130  flattened A operands; client i uses [i*130 +: 130].
- req_b  in  NUM_REQ*128  flattened B operands; client i uses [i*128 +: 128].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept strobe.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe.
- rsp_product  out  258  product for the client flagged in rsp_valid.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- arb_busy  out  1  high whenever the FSM is not in IDLE.
- mul_start  out  1  start to the multiplier.
- mul_a  out  130  A operand to the multiplier.
- mul_b  out  128  B operand to the multiplier.
- mul_busy  in  1  multiplier busy.
- mul_done  in  1  multiplier one-cycle done pulse.
- mul_product  in  258  multiplier result, valid when mul_done is high.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, latched operands 0, grant id 0, timeout counter 0. Reset takes effect immediately and may occur in any state.
- After reset mid-operation, a late mul_done from the multiplier arrives in IDLE and is ignored. No response is generated for the aborted job.
- IDLE:
  - If any req_valid bit is set, grant the first set bit found scanning upward from the pointer with wrap-around.
  - In the same cycle, req_ready[g]=1 combinationally from registered state, and req_a/req_b slice g is latched into mul_a/mul_b.
  - Next state is ISSUE. If no request is set, stay in IDLE.
- ISSUE:
  - mul_start=1.
  - If mul_busy=0 at the clock edge, the start is taken: go to WAIT and clear the timeout counter.
  - Otherwise stay in ISSUE, keeping mul_start high and operands stable.
- WAIT:
  - mul_start=0; operands held.
  - On mul_done=1: capture mul_product into rsp_product, set rsp_err=0, go to RESP.
  - The timeout counter increments every WAIT cycle.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle.
  - Pointer becomes (g+1) mod NUM_REQ.
  - Next state is IDLE.
  - rsp_product holds its value until the next capture.
- Throughput and latency:
  - One job in flight at a time.
  - The request-to-response overhead is 3 cycles beyond the multiplier's start-to-done latency: accept cycle, ISSUE cycle, RESP cycle.
  - A new accept can occur in the cycle after RESP.
- Fairness: after client g is served it has the lowest priority. With all clients continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0.
- req_valid changes while a job is in flight do not affect the job. A client's req_valid deasserted before its req_ready strobe is simply not served.
- mul_done seen outside WAIT is ignored.
- The client owns its result: rsp_valid has no backpressure.

Optional Feature:
- Macro: MULT_ARB_TIMEOUT_EN.
- Defined:
  - If the WAIT counter reaches TIMEOUT_CYCLES without mul_done, go to RESP with rsp_product=0 and rsp_err=1 for client g.
  - The pointer advances as normal.
  - A subsequent stray mul_done is ignored.
- Undefined: no counter logic, rsp_err is tied to 0, and WAIT lasts until mul_done.

Test Plan:
- Single request: client 0 with a=3, b=5, multiplier model idle.
  - req_ready[0] pulses once; mul_start pulses one cycle with mul_a=3, mul_b=5.
  - After mul_done, rsp_valid=2'b01 and rsp_product=15, rsp_err=0.
- Contention: clients 0 and 1 request together, pointer 0.
  - Client 0 is served first, then client 1.
  - Both held for 4 jobs: grant order 0,1,0,1, each rsp_valid one-hot and one cycle.
- Busy multiplier: mul_busy=1 for 5 cycles on ISSUE entry.
  - mul_start stays high 6 cycles with constant operands; WAIT is entered only after mul_busy falls.
- Wide operands: a=2^130-1, b=2^128-1.
  - rsp_product = (2^130-1)*(2^128-1) in full 258 bits, including the MSB.
- Reset mid-WAIT: assert reset for 1 cycle.
  - All outputs are 0 immediately.
  - A later mul_done produces no rsp_valid; the next request is served from pointer 0.
- With MULT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mul_done never asserted:
  - rsp_valid pulses after 8 WAIT cycles with rsp_err=1 and rsp_product=0.
  - Without the macro, the FSM stays in WAIT.
